// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage.
// Opcodes, control bundle, occupancy states and width defaults.
package ex_mem_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_AW_DEF = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
  } ctrl_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_e;

  // Only mul and div produce an upper half worth keeping.
  function automatic logic is_hi_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Generic 2-entry skid buffer over a packed payload.
// Registered in_ready; strict FIFO order; flush empties it.
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q;
  logic         acc, pop;

  assign acc       = in_valid & in_ready_q;
  assign pop       = (state_q != OCC_EMPTY) & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = head_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (acc) begin
            state_d = OCC_ONE;
            head_d  = in_data;
          end
        end
        OCC_ONE: begin
          unique case ({acc, pop})
            2'b10: begin
              state_d = OCC_TWO;
              skid_d  = in_data;
            end
            2'b01: state_d = OCC_EMPTY;
            2'b11: head_d = in_data;
            default: ;
          endcase
        end
        OCC_TWO: begin
          if (pop) begin
            state_d = OCC_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      // Looking at next state keeps out_ready off the in_ready path.
      in_ready_q <= (state_d != OCC_TWO);
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: skid-buffered ALU results, branch resolve, HI reg.
// Define EX_MEM_FWD_EN to add head-entry forwarding outputs.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic              alu_zero,
  input  logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              branch,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_reg_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] hi_value
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int PW = 2 * DATA_W + REG_AW + 3;

  ctrl_t             ctrl_in;
  logic [PW-1:0]     pay_in, pay_out;
  logic              acc;
  logic              br_q, br_d;
  logic [DATA_W-1:0] hi_q, hi_d;

  assign ctrl_in = {mem_read, mem_write, reg_write, branch};
  assign pay_in  = {alu_result, store_data, rd_addr,
                    ctrl_in.mem_read, ctrl_in.mem_write,
                    ctrl_in.reg_write};

  ex_mem_skid #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pay_in),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pay_out)
  );

  assign {out_result, out_store_data, out_rd_addr,
          out_mem_read, out_mem_write, out_reg_write} = pay_out;

  assign acc = in_valid & in_ready;

  // A flushed beat never existed: no branch pulse, no HI update.
  always_comb begin
    br_d = acc & ~flush & ctrl_in.branch & alu_zero;
    hi_d = hi_q;
    if (acc && !flush && is_hi_op(alu_opcode)) hi_d = alu_hi;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_q <= 1'b0;
      hi_q <= '0;
    end else begin
      br_q <= br_d;
      hi_q <= hi_d;
    end
  end

  assign branch_taken = br_q;
  assign hi_value     = hi_q;

`ifdef EX_MEM_FWD_EN
  assign fwd_valid = out_valid & out_reg_write & ~out_mem_read
                   & (out_rd_addr != '0);
  assign fwd_rd    = out_rd_addr;
  assign fwd_data  = out_result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage.
// Hand-computed expectations, immediate assertions per check.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic [63:0] alu_hi;
  logic        alu_zero;
  logic [3:0]  alu_opcode;
  logic [63:0] store_data;
  logic [4:0]  rd_addr;
  logic        mem_read, mem_write, reg_write, branch;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result, out_store_data;
  logic [4:0]  out_rd_addr;
  logic        out_mem_read, out_mem_write, out_reg_write;
  logic        branch_taken;
  logic [63:0] hi_value;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_result    (alu_result),
    .alu_hi        (alu_hi),
    .alu_zero      (alu_zero),
    .alu_opcode    (alu_opcode),
    .store_data    (store_data),
    .rd_addr       (rd_addr),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .branch        (branch),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_store_data(out_store_data),
    .out_rd_addr   (out_rd_addr),
    .out_mem_read  (out_mem_read),
    .out_mem_write (out_mem_write),
    .out_reg_write (out_reg_write),
    .branch_taken  (branch_taken),
    .hi_value      (hi_value)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] res, input logic [3:0] op,
                      input logic [63:0] hi);
    in_valid   = 1'b1;
    alu_result = res;
    alu_opcode = op;
    alu_hi     = hi;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 0; alu_result = 0; alu_hi = 0; alu_zero = 0;
    alu_opcode = ALU_ADD; store_data = 0; rd_addr = 0;
    mem_read = 0; mem_write = 0; reg_write = 0; branch = 0;
    flush = 0; out_ready = 0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_hi", hi_value, 0);
    check("rst_branch", branch_taken, 0);
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // single beat
    beat(64'h1234, ALU_ADD, 64'h0);
    rd_addr = 5; reg_write = 1; out_ready = 1;
    tick();
    in_valid = 0;
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 64'h1234);
    check("single_rd", out_rd_addr, 5);
    check("single_rw", out_reg_write, 1);
    tick();
    check("single_drain", out_valid, 0);

    // backpressure: A, B accepted, C held
    out_ready = 0; reg_write = 0;
    beat(64'hA, ALU_OR, 64'h0);
    tick();
    check("bp_ready_one", in_ready, 1);
    beat(64'hB, ALU_AND, 64'h0);
    tick();
    check("bp_ready_two", in_ready, 0);
    check("bp_head_a", out_result, 64'hA);
    beat(64'hC, ALU_SUB, 64'h0);
    tick();
    check("bp_hold_ready", in_ready, 0);
    check("bp_hold_head", out_result, 64'hA);
    out_ready = 1;
    tick();
    check("bp_head_b", out_result, 64'hB);
    check("bp_ready_after_pop", in_ready, 1);
    tick();
    in_valid = 0;
    check("bp_head_c", out_result, 64'hC);
    check("bp_c_valid", out_valid, 1);
    tick();
    check("bp_empty", out_valid, 0);

    // branch resolution
    beat(64'h55, ALU_SUB, 64'h0);
    branch = 1; alu_zero = 1;
    tick();
    in_valid = 0; branch = 0; alu_zero = 0;
    check("br_taken", branch_taken, 1);
    check("br_beat_buffered", out_result, 64'h55);
    tick();
    check("br_one_cycle", branch_taken, 0);
    beat(64'h56, ALU_SUB, 64'h0);
    branch = 1; alu_zero = 0;
    tick();
    in_valid = 0; branch = 0;
    check("br_not_taken", branch_taken, 0);
    tick();

    // HI capture
    beat(64'h1, ALU_MUL, 64'hDEAD);
    tick();
    check("hi_mul", hi_value, 64'hDEAD);
    beat(64'h2, ALU_ADD, 64'hBEEF);
    tick();
    check("hi_after_add", hi_value, 64'hDEAD);
    beat(64'h77, 4'b1111, 64'hF00D);
    tick();
    in_valid = 0;
    check("hi_bad_op", hi_value, 64'hDEAD);
    check("bad_op_pass", out_result, 64'h77);
    tick();

    // flush with accept in EMPTY: beat discarded, no pulse, no HI
    out_ready = 0;
    beat(64'h99, ALU_MUL, 64'h7777);
    branch = 1; alu_zero = 1; flush = 1;
    tick();
    in_valid = 0; branch = 0; alu_zero = 0; flush = 0;
    check("fl1_valid", out_valid, 0);
    check("fl1_branch", branch_taken, 0);
    check("fl1_hi", hi_value, 64'hDEAD);

    // flush while TWO with a mul offered
    beat(64'h111, ALU_ADD, 64'h0);
    tick();
    beat(64'h222, ALU_ADD, 64'h0);
    tick();
    check("fl2_full", in_ready, 0);
    beat(64'h333, ALU_MUL, 64'h9999);
    flush = 1;
    tick();
    in_valid = 0; flush = 0;
    check("fl2_valid", out_valid, 0);
    check("fl2_ready", in_ready, 1);
    check("fl2_hi", hi_value, 64'hDEAD);
    out_ready = 1;
    tick();
    check("fl2_stays_empty", out_valid, 0);
    beat(64'h444, ALU_ADD, 64'h0);
    tick();
    in_valid = 0;
    check("post_flush_beat", out_result, 64'h444);
    tick();

    // async reset mid-stall
    out_ready = 0;
    beat(64'h500, ALU_ADD, 64'h0);
    tick();
    beat(64'h600, ALU_ADD, 64'h0);
    tick();
    in_valid = 0;
    check("ar_full", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready, 0);
    check("ar_result", out_result, 0);
    check("ar_hi", hi_value, 0);
    tick();
    reset = 1'b1;
    out_ready = 1;
    tick();
    check("ar_rel_ready", in_ready, 1);
    check("ar_rel_empty", out_valid, 0);
    tick();
    check("ar_stays_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
